// File: rtl/spe_combiner.sv
// Summing PE: folds FILTER_SIZE row partial sums and one residual into a pixel
// accumulator, thresholds it and emits {pixel, spike, new residual} to OFMAP.
module spe_combiner #(
  parameter int FILTER_SIZE  = 5,
  parameter int OUTPUT_DIM   = 21,
  parameter int THRESHOLD    = 64,
  parameter int OFMAP_MEM_ID = 11,
  parameter int PS_WIDTH     = 14,
  parameter int RES_WIDTH    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [29:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [8:0]  pixel_idx,
  output logic        frame_done,
  output logic        err_dup
);

  localparam int ACC_W = 20;
  localparam int CNT_W = $clog2(FILTER_SIZE + 1);
  localparam int NPIX  = OUTPUT_DIM * OUTPUT_DIM;

  localparam logic [CNT_W-1:0] FS_CNT = CNT_W'(FILTER_SIZE);
  localparam logic [8:0]       PIX_LAST = 9'(NPIX - 1);
  localparam logic [3:0]       DEST = 4'(OFMAP_MEM_ID);
  localparam logic signed [ACC_W-1:0] THR = ACC_W'(THRESHOLD);
  localparam logic signed [ACC_W-1:0] RES_MAX =
    ACC_W'((1 << (RES_WIDTH - 1)) - 1);
  localparam logic signed [ACC_W-1:0] RES_MIN =
    -ACC_W'(1 << (RES_WIDTH - 1));

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    COMPUTE = 2'd1,
    SEND    = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]         ps_cnt_q, ps_cnt_d;
  logic                     res_seen_q, res_seen_d;
  logic [29:0]              out_data_q, out_data_d;
  logic [8:0]               pixel_q, pixel_d;
  logic                     frame_done_q, frame_done_d;
  logic                     err_dup_q, err_dup_d;

  logic                     is_res;
  logic signed [ACC_W-1:0]  ps_ext;
  logic signed [ACC_W-1:0]  res_ext;
  logic                     in_fire;
  logic                     spike;
  logic signed [ACC_W-1:0]  new_res;
  logic [RES_WIDTH-1:0]     res_sat;
  logic                     unused_bits;

  assign is_res  = in_data[25];
  assign ps_ext  = {{(ACC_W-PS_WIDTH){in_data[PS_WIDTH-1]}},
                    in_data[PS_WIDTH-1:0]};
  assign res_ext = {{(ACC_W-RES_WIDTH){in_data[RES_WIDTH-1]}},
                    in_data[RES_WIDTH-1:0]};
  assign unused_bits = ^{in_data[29:26], in_data[24:RES_WIDTH]};

  // A full set of row sums stalls only further partial sums, never a residual.
  assign in_ready = !reset && (state_q == COLLECT) &&
                    (is_res || (ps_cnt_q != FS_CNT));
  assign in_fire  = in_valid && in_ready;

  assign spike   = (acc_q >= THR);
  assign new_res = spike ? (acc_q - THR) : acc_q;

  always_comb begin
    res_sat = new_res[RES_WIDTH-1:0];
    if (new_res > RES_MAX) begin
      res_sat = RES_MAX[RES_WIDTH-1:0];
    end else if (new_res < RES_MIN) begin
      res_sat = RES_MIN[RES_WIDTH-1:0];
    end
  end

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    ps_cnt_d     = ps_cnt_q;
    res_seen_d   = res_seen_q;
    out_data_d   = out_data_q;
    pixel_d      = pixel_q;
    frame_done_d = 1'b0;
    err_dup_d    = err_dup_q;
    unique case (state_q)
      COLLECT: begin
        if (in_fire) begin
          if (!is_res) begin
            acc_d    = acc_q + ps_ext;
            ps_cnt_d = ps_cnt_q + 1'b1;
          end else if (res_seen_q) begin
            err_dup_d = 1'b1;
          end else begin
            acc_d      = acc_q + res_ext;
            res_seen_d = 1'b1;
          end
          if ((ps_cnt_d == FS_CNT) && res_seen_d) begin
            state_d = COMPUTE;
          end
        end
      end
      COMPUTE: begin
        out_data_d = {DEST, spike, pixel_q, res_sat};
        state_d    = SEND;
      end
      SEND: begin
        if (out_ready) begin
          state_d    = COLLECT;
          acc_d      = '0;
          ps_cnt_d   = '0;
          res_seen_d = 1'b0;
          if (pixel_q == PIX_LAST) begin
            pixel_d      = '0;
            frame_done_d = 1'b1;
          end else begin
            pixel_d = pixel_q + 9'd1;
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= COLLECT;
      acc_q        <= '0;
      ps_cnt_q     <= '0;
      res_seen_q   <= 1'b0;
      out_data_q   <= '0;
      pixel_q      <= '0;
      frame_done_q <= 1'b0;
      err_dup_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      ps_cnt_q     <= ps_cnt_d;
      res_seen_q   <= res_seen_d;
      out_data_q   <= out_data_d;
      pixel_q      <= pixel_d;
      frame_done_q <= frame_done_d;
      err_dup_q    <= err_dup_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = (state_q == SEND);
  assign pixel_idx  = pixel_q;
  assign frame_done = frame_done_q;
  assign err_dup    = err_dup_q;

endmodule

// File: tb/tb_spe_combiner.sv
// Bench for spe_combiner: vector table plus scoreboard on the result port,
// with hand-written back-pressure, stall, frame-wrap, error and reset cases.
module tb_spe_combiner;

  logic        clk = 1'b0;
  logic        reset;
  logic [29:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [29:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [8:0]  pixel_idx;
  logic        frame_done;
  logic        err_dup;

  always #5 clk = ~clk;

  spe_combiner dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .pixel_idx  (pixel_idx),
    .frame_done (frame_done),
    .err_dup    (err_dup)
  );

  typedef struct {
    int ps[5];
    int res;
    bit res_first;
    bit sp;
    int r;
  } vec_t;

  int          total = 0;
  int          bad = 0;
  int          fd_cnt = 0;
  bit          fd_pend = 1'b0;
  int          exp_pix = 0;
  logic [29:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    logic [29:0] e;
    if (reset) begin
      fd_pend = 1'b0;
    end else begin
      if (frame_done || fd_pend) begin
        if (frame_done) fd_cnt++;
        chk("frame_done", 32'(frame_done), 32'(fd_pend));
      end
      fd_pend = 1'b0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL out_extra: got %0h want none", out_data);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", 32'(out_data), 32'(e));
          if (e[24:16] == 9'd440) fd_pend = 1'b1;
        end
      end
    end
  end

  task automatic push(input bit sp, input int r);
    logic [31:0] rv;
    logic [31:0] pv;
    rv = r;
    pv = exp_pix;
    exp_q.push_back({4'd11, sp, pv[8:0], rv[15:0]});
    exp_pix = (exp_pix + 1) % 441;
  endtask

  task automatic push_sum(input int s);
    bit sp;
    int r;
    sp = (s >= 64);
    r = sp ? s - 64 : s;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    push(sp, r);
  endtask

  task automatic send_pkt(input bit op, input int val);
    logic [31:0] v;
    bit ok;
    v = val;
    ok = 1'b0;
    in_data = {4'd5, op, v[24:0]};
    in_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL in_timeout: got ready=0 want ready=1 op=%0d", op);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_pixel(input int ps[5], input int res, input bit rf);
    if (rf) send_pkt(1'b1, res);
    for (int i = 0; i < 5; i++) send_pkt(1'b0, ps[i]);
    if (!rf) send_pkt(1'b1, res);
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[8];

  initial begin
    int ps[5];
    int s;
    bit ok;

    vecs[0] = '{ps:'{10, 20, 30, -5, 5}, res:0, res_first:0, sp:0, r:60};
    vecs[1] = '{ps:'{20, 20, 20, 20, 20}, res:10, res_first:1, sp:1, r:46};
    vecs[2] = '{ps:'{0, 0, 0, 0, 64}, res:0, res_first:0, sp:1, r:0};
    vecs[3] = '{ps:'{0, 0, 0, 0, 63}, res:0, res_first:1, sp:0, r:63};
    vecs[4] = '{ps:'{-8192, -8192, -8192, -8192, -8192}, res:-32768,
                res_first:0, sp:0, r:-32768};
    vecs[5] = '{ps:'{8191, 8191, 8191, 8191, 8191}, res:32767,
                res_first:1, sp:1, r:32767};
    vecs[6] = '{ps:'{-100, 50, 0, 0, 0}, res:-20, res_first:0, sp:0, r:-70};
    vecs[7] = '{ps:'{100, 0, 0, 0, 0}, res:30000, res_first:0, sp:1,
                r:30036};

    reset = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_pixel", 32'(pixel_idx), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_err_dup", 32'(err_dup), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    for (int k = 0; k < 8; k++) begin
      push(vecs[k].sp, vecs[k].r);
      run_pixel(vecs[k].ps, vecs[k].res, vecs[k].res_first);
    end
    drain();

    // back-pressure: result held while NoC is not ready
    out_ready = 1'b0;
    ps = '{1, 2, 3, 4, 5};
    push_sum(15 + 7);
    run_pixel(ps, 7, 1'b0);
    in_data = {4'd0, 1'b0, 25'd1};
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk("bp_valid_seen", 32'(ok), 32'd1);
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_data", 32'(out_data), 32'({4'd11, 1'b0, 9'd8, 16'd22}));
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_in_ready_after", 32'(in_ready), 32'd1);
    chk("bp_out_valid_after", 32'(out_valid), 32'd0);
    chk("bp_sb_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;

    // sixth partial sum stalls until the next pixel
    push_sum(15 + 100);
    for (int i = 0; i < 5; i++) send_pkt(1'b0, i + 1);
    in_data = {4'd0, 1'b0, 25'd7};
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("extra_ps_stall", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    send_pkt(1'b1, 100);
    drain();
    push_sum(7 + 4 + 5);
    send_pkt(1'b0, 7);
    for (int i = 0; i < 4; i++) send_pkt(1'b0, 1);
    send_pkt(1'b1, 5);
    drain();

    // duplicate residual is discarded and flagged
    push_sum(5 + 50);
    send_pkt(1'b1, 5);
    send_pkt(1'b1, 999);
    @(negedge clk);
    chk("err_dup_set", 32'(err_dup), 32'd1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) send_pkt(1'b0, 10);
    drain();
    chk("pixel_before_fill", 32'(pixel_idx), 32'd12);

    for (int p = 12; p < 441; p++) begin
      if (p == 440) begin
        ps = '{8191, 8191, 8191, 8191, 8191};
        push(1'b1, 32767);
        run_pixel(ps, 32767, 1'b0);
      end else begin
        s = 0;
        for (int i = 0; i < 5; i++) begin
          ps[i] = int'($urandom_range(0, 400)) - 200;
          s += ps[i];
        end
        push_sum(s + p);
        run_pixel(ps, p, p[0]);
      end
    end
    drain();
    @(negedge clk);
    chk("frame_done_count", 32'(fd_cnt), 32'd1);
    chk("pixel_wrapped", 32'(pixel_idx), 32'd0);
    @(posedge clk);
    #1;

    // reset mid-collect drops the partial pixel and the error flag
    ps = '{3, 3, 3, 3, 3};
    push_sum(15 - 2);
    run_pixel(ps, -2, 1'b0);
    drain();
    for (int i = 0; i < 3; i++) send_pkt(1'b0, 1000);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("mid_rst_pixel", 32'(pixel_idx), 32'd0);
    chk("mid_rst_err_dup", 32'(err_dup), 32'd0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_data", 32'(out_data), 32'd0);
    chk("mid_rst_frame_done", 32'(frame_done), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_pix = 0;
    exp_q.delete();
    ps = '{1, 2, 3, 4, 5};
    push(1'b0, 15);
    run_pixel(ps, 0, 1'b1);
    drain();
    @(negedge clk);
    chk("post_rst_pixel", 32'(pixel_idx), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spe_combiner.md
# spe_combiner

Summing PE (SPE) stage directly downstream of the partial-sum PEs in the NoC convolution array. It collects the FILTER_SIZE row partial sums for one output pixel, plus that pixel's residual membrane potential from the OFMAP memory. It adds them, applies the spike threshold, and sends one packet carrying {pixel index, spike, new residual} to the OFMAP memory. It is clocked, with valid/ready packet handshakes on both sides; the network interface converts to and from CSP channels.

## Interface
- FILTER_SIZE, 5, partial sums per output pixel (one per filter row)
- OUTPUT_DIM, 21, output feature-map side; pixels per frame = OUTPUT_DIM*OUTPUT_DIM
- THRESHOLD, 64, signed spike threshold
- OFMAP_MEM_ID, 11, 4-bit destination address stamped on every output packet
- PS_WIDTH, 14, signed partial-sum width
- RES_WIDTH, 16, signed residual width
- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- in_data  in  30  packet: [29:26] dest (ignored), [25] opcode, [24:0] data
- in_valid  in  1  packet present
- in_ready  out  1  block accepts packet this cycle
- out_data  out  30  result packet
- out_valid  out  1  result present
- out_ready  in  1  NoC accepts result
- pixel_idx  out  9  index of pixel currently being collected
- frame_done  out  1  one-cycle pulse when the last pixel of a frame is sent
- err_dup  out  1  sticky: second residual packet received for the same pixel

## Operation
- Input opcode 0: partial sum = in_data[PS_WIDTH-1:0], sign-extended; adds it to acc and increments ps_cnt.
- Input opcode 1: residual = in_data[RES_WIDTH-1:0], sign-extended; adds it to acc and sets res_seen. If res_seen is already 1, the value is discarded and err_dup is set; err_dup is cleared only by reset.
- Arrival order is arbitrary. The pixel is complete when ps_cnt==FILTER_SIZE and res_seen==1.
- A partial sum arriving when ps_cnt==FILTER_SIZE is back-pressured; in_ready is 0 for opcode 0 in that case.
- acc is 20-bit signed. Its maximum magnitude is FILTER_SIZE*2^13 + 2^15, so acc never overflows.
- Spike rule: spike = (acc >= THRESHOLD). new_res = spike ? acc-THRESHOLD : acc. new_res saturates to the RES_WIDTH signed range.
- Output packet: [29:26]=OFMAP_MEM_ID, [25]=spike, [24:16]=pixel_idx, [15:0]=new_res.
- After the out handshake: acc, ps_cnt and res_seen clear. pixel_idx increments, wrapping from OUTPUT_DIM^2-1 to 0; frame_done pulses on the wrap.
- States:
  - COLLECT: in_ready=1, except for the back-pressure case above. Goes to COMPUTE on the cycle after completion.
  - COMPUTE: one cycle; registers out_data; goes to SEND.
  - SEND: out_valid=1; out_data is held stable until out_ready. Then returns to COLLECT.
- in_ready=0 in COMPUTE and SEND; no input is accepted while a result is pending.

## Timing
- Reset values: in_ready=0 during reset and 1 on the first cycle after, out_valid=0, out_data=0, pixel_idx=0, frame_done=0, err_dup=0. State=COLLECT, acc=0, ps_cnt=0, res_seen=0.
- Handshake: a transfer occurs on a rising edge where valid && ready. The source holds data and valid until the transfer.
- Latency: the completing packet is accepted at edge N. COMPUTE runs in cycle N+1. out_valid=1 from edge N+2.
- Throughput: one pixel per FILTER_SIZE+1 input transfers + 2 cycles, minimum.
- A result accepted at edge M puts in_ready=1 in cycle M+1.
- frame_done is high exactly in cycle M+1 following the handshake of pixel OUTPUT_DIM^2-1.
- Reset asserted in any state, including mid-collect or during SEND with out_ready low: the partial pixel is dropped and the block returns to reset values at the next edge. Any output not yet transferred is lost.
- Saturation: new_res > 32767 gives 32767; new_res < -32768 gives -32768.

## Test plan
- Basic: partial sums 10,20,30,-5,5 and residual 0 -> acc=60; packet spike=0, res=60, pixel 0; dest field=11.
- Spike: partial sums 20×5 and residual 10 -> acc=110; spike=1, res=46. Residual arrives first, to check that arrival order does not matter.
- Back-pressure: complete a pixel, then hold out_ready=0 for 7 cycles -> out_data stable and in_ready=0 throughout. Raise out_ready -> one transfer, and in_ready=1 on the next cycle.
- Extra partial sum: send 6 partial sums before the residual -> the 6th stalls (in_ready=0 for it). After the residual completes the pixel and the result is sent, the 6th is accepted as pixel 1's first sum.
- Frame wrap and saturation: run 441 pixels, the last with partial sums 8191×5 and residual 32767 -> res=32767 (saturated). frame_done pulses once and pixel_idx returns to 0.
- Errors and reset: a second residual for the same pixel -> err_dup=1 and the value is ignored. Assert reset mid-collect with ps_cnt=3 -> all outputs at reset values, err_dup=0, and the next pixel starts from acc=0.
